// File: rtl/vector_matrix_multiply_row_unit.sv
// Vector-matrix multiply row unit: O[j] = sum_k A[k] * W[k][j].
// One signed multiply-accumulate per cycle, k inner loop, j outer loop.
// Operands are captured when a start is accepted, so later input changes do
// not affect the running operation.
//
// Ports:
//   clk             - clock, all state updates on rising edge
//   rst_n           - asynchronous active-low reset
//   op_start        - start request, accepted only in idle
//   input_vector_A  - signed input row vector [0:K_DIM-1]
//   weight_matrix_W - signed weight matrix [0:K_DIM-1][0:N_DIM-1]
//   output_vector_O - registered result vector [0:N_DIM-1], held until next completion
//   op_busy         - high while MACs are in progress
//   op_done         - one-cycle completion pulse, O valid while high
module vector_matrix_multiply_row_unit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned K_DIM       = 2,
  parameter int unsigned N_DIM       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_start,
  input  logic signed [DATA_WIDTH-1:0]  input_vector_A  [0:K_DIM-1],
  input  logic signed [DATA_WIDTH-1:0]  weight_matrix_W [0:K_DIM-1][0:N_DIM-1],
  output logic signed [ACCUM_WIDTH-1:0] output_vector_O [0:N_DIM-1],
  output logic                          op_busy,
  output logic                          op_done
);

  localparam int unsigned KIdxW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int unsigned JIdxW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam logic [KIdxW-1:0] KLast = KIdxW'(K_DIM - 1);
  localparam logic [JIdxW-1:0] JLast = JIdxW'(N_DIM - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                        state_q;
  logic [KIdxW-1:0]              k_q;
  logic [JIdxW-1:0]              j_q;
  logic signed [DATA_WIDTH-1:0]  a_q   [0:K_DIM-1];
  logic signed [DATA_WIDTH-1:0]  w_q   [0:K_DIM-1][0:N_DIM-1];
  logic signed [ACCUM_WIDTH-1:0] acc_q [0:N_DIM-1];

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACCUM_WIDTH-1:0]  mac_sum;

  // Full-precision product, sign-extended before a wrapping accumulate.
  always_comb begin
    prod    = a_q[k_q] * w_q[k_q][j_q];
    mac_sum = acc_q[j_q] + ACCUM_WIDTH'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      j_q     <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      for (int unsigned k = 0; k < K_DIM; k++) begin
        a_q[k] <= '0;
        for (int unsigned n = 0; n < N_DIM; n++) begin
          w_q[k][n] <= '0;
        end
      end
      for (int unsigned n = 0; n < N_DIM; n++) begin
        acc_q[n]           <= '0;
        output_vector_O[n] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          op_done <= 1'b0;
          if (op_start) begin
            a_q     <= input_vector_A;
            w_q     <= weight_matrix_W;
            k_q     <= '0;
            j_q     <= '0;
            op_busy <= 1'b1;
            state_q <= StCompute;
            for (int unsigned n = 0; n < N_DIM; n++) begin
              acc_q[n] <= '0;
            end
          end
        end
        StCompute: begin
          acc_q[j_q] <= mac_sum;
          if (k_q == KLast) begin
            k_q <= '0;
            if (j_q == JLast) begin
              // Final MAC: publish results including this cycle's sum.
              op_busy <= 1'b0;
              op_done <= 1'b1;
              state_q <= StDone;
              for (int unsigned n = 0; n < N_DIM; n++) begin
                output_vector_O[n] <= (JIdxW'(n) == j_q) ? mac_sum : acc_q[n];
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          op_done <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          op_busy <= 1'b0;
          op_done <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_matrix_multiply_row_unit.sv
module tb_vector_matrix_multiply_row_unit;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int K   = 2;
  localparam int N   = 2;
  localparam int LAT = K * N;

  logic                 clk;
  logic                 rst_n;
  logic                 op_start;
  logic signed [DW-1:0] a_in  [0:K-1];
  logic signed [DW-1:0] w_in  [0:K-1][0:N-1];
  logic signed [AW-1:0] o_out [0:N-1];
  logic                 busy;
  logic                 done;

  typedef logic [N-1:0][AW-1:0] res_t;
  typedef struct packed {
    res_t o;
    int   done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  res_t prev_o;
  res_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  vector_matrix_multiply_row_unit #(
    .DATA_WIDTH (DW),
    .ACCUM_WIDTH(AW),
    .K_DIM      (K),
    .N_DIM      (N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_start       (op_start),
    .input_vector_A (a_in),
    .weight_matrix_W(w_in),
    .output_vector_O(o_out),
    .op_busy        (busy),
    .op_done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
    end
  endtask

  // Reference: plain dot products, truncated to the accumulator width.
  function automatic res_t model();
    res_t   r;
    longint s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < K; k++) s += longint'(a_in[k]) * longint'(w_in[k][j]);
      r[j] = s[AW-1:0];
    end
    return r;
  endfunction

  task automatic set_ops(input logic signed [DW-1:0] a0, a1, w00, w01, w10, w11);
    a_in[0]    = a0;
    a_in[1]    = a1;
    w_in[0][0] = w00;
    w_in[0][1] = w01;
    w_in[1][0] = w10;
    w_in[1][1] = w11;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < K; k++) begin
      a_in[k] = 8'($urandom_range(0, 255));
      for (int j = 0; j < N; j++) w_in[k][j] = 8'($urandom_range(0, 255));
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
  task automatic start_op(input bit push);
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    cur_exp  = model();
    if (push) sb_q.push_back('{o: cur_exp, done_cyc: cyc + LAT});
  endtask

  task automatic wait_complete(input bit disturb);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("busy_in_compute", 32'(busy), 32'd1);
      check("no_done_in_compute", 32'(done), 32'd0);
      for (int j = 0; j < N; j++) check("O_holds_during_compute", o_out[j], prev_o[j]);
      if (disturb && i == 1) begin
        rand_ops();
        op_start = 1'b1;
      end
      if (disturb && i == 2) op_start = 1'b0;
    end
    @(negedge clk);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    prev_o = cur_exp;
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_o(input string name, input int e0, input int e1);
    check(name, o_out[0], e0);
    check(name, o_out[1], e1);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got op_done=1 expected no pending operation");
      end else begin
        mon_e = sb_q.pop_front();
        for (int j = 0; j < N; j++) check("result_O", o_out[j], mon_e.o[j]);
        check("done_latency_cycle", cyc, mon_e.done_cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    op_start = 1'b0;
    prev_o   = '0;
    cur_exp  = '0;
    set_ops(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_o("reset_O", 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic
    set_ops(1, 2, 3, 4, 5, 6);
    start_op(1);
    wait_complete(0);
    check_o("basic_O", 13, 16);

    // Signed extremes
    set_ops(-128, 127, -128, 127, 1, -1);
    start_op(1);
    wait_complete(0);
    check_o("extremes_O", 16511, -16383);

    // Operand isolation with a start pulse during compute
    set_ops(1, 2, 3, 4, 5, 6);
    start_op(1);
    wait_complete(1);
    check_o("isolation_O", 13, 16);
    repeat (8) @(negedge clk);
    check("isolation_no_extra_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation
    set_ops(1, 2, 3, 4, 5, 6);
    start_op(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check_o("midreset_O", 0, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    prev_o = '0;
    repeat (8) @(negedge clk);
    check("after_reset_idle", 32'(busy), 32'd0);
    check_o("after_reset_O", 0, 0);
    @(posedge clk);
    #1;
    start_op(1);
    wait_complete(0);
    check_o("post_reset_basic_O", 13, 16);

    // Back-to-back: basic, then A=[0,-1]; O must hold between completions
    start_op(1);
    wait_complete(0);
    set_ops(0, -1, 3, 4, 5, 6);
    check_o("b2b_hold_O", 13, 16);
    start_op(1);
    wait_complete(0);
    check_o("b2b_second_O", -5, -6);

    // Zero input
    rand_ops();
    a_in[0] = '0;
    a_in[1] = '0;
    start_op(1);
    wait_complete(0);
    check_o("zero_O", 0, 0);

    // op_start held high: restart at each return to idle (every LAT+2 cycles)
    set_ops(1, 2, 3, 4, 5, 6);
    op_start = 1'b1;
    @(posedge clk);
    #1;
    cur_exp = model();
    sb_q.push_back('{o: cur_exp, done_cyc: cyc + LAT});
    sb_q.push_back('{o: cur_exp, done_cyc: cyc + 2 * LAT + 2});
    repeat (LAT + 3) @(negedge clk);
    op_start = 1'b0;
    repeat (LAT) @(negedge clk);
    prev_o = cur_exp;
    @(posedge clk);
    #1;
    check("held_start_queue_drained", sb_q.size(), 0);

    // Randomized operands
    repeat (20) begin
      rand_ops();
      start_op(1);
      wait_complete(0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
